// File: rtl/multiplexer_pkg.sv
// multiplexer_pkg: shared select codes and address type for the registered 2:1 selector
package multiplexer_pkg;
  localparam int ADDR_W = 3;
  localparam logic [2:0] SEL_A = 3'b001;
  localparam logic [2:0] SEL_B = 3'b010;
  typedef logic [ADDR_W-1:0] mux_addr_t;
endpackage

// File: rtl/mux_sel_decode.sv
// mux_sel_decode: one-hot ADDR decoder; exactly one of sel_a/sel_b/illegal is high
module mux_sel_decode
  import multiplexer_pkg::*;
(
  input  mux_addr_t addr,
  output logic      sel_a,
  output logic      sel_b,
  output logic      illegal
);
  // Case equality makes X/Z codes fall through to illegal in simulation.
  always_comb begin
    sel_a   = (addr === SEL_A);
    sel_b   = (addr === SEL_B);
    illegal = !(sel_a || sel_b);
  end
endmodule

// File: rtl/multiplexer.sv
// multiplexer: registered 2:1 selector with one-hot ADDR and illegal-code flag
// MULTIPLEXER_HOLD_ON_INVALID_EN: hold OUTPUT on illegal codes instead of clearing it
module multiplexer
  import multiplexer_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  mux_addr_t        ADDR,
  output logic [WIDTH-1:0] OUTPUT,
  output logic             ADDR_ERR
);
  logic             sel_a, sel_b, illegal;
  logic [WIDTH-1:0] output_d, output_q;
  logic             addr_err_d, addr_err_q;
  mux_sel_decode u_dec (
    .addr    (ADDR),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .illegal (illegal)
  );
  always_comb begin
`ifdef MULTIPLEXER_HOLD_ON_INVALID_EN
    output_d   = sel_a ? A : sel_b ? B : output_q;
`else
    output_d   = sel_a ? A : sel_b ? B : '0;
`endif
    addr_err_d = illegal;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      output_q   <= output_d;
      addr_err_q <= addr_err_d;
    end
  end
  assign OUTPUT   = output_q;
  assign ADDR_ERR = addr_err_q;
endmodule

// File: tb/tb_multiplexer.sv
// tb_multiplexer: directed scoreboard bench for multiplexer (WIDTH=1)
module tb_multiplexer;
  logic       clk;
  logic       rst_n;
  logic       a, b;
  logic [2:0] addr;
  logic       out_w, err_w;
  int         checks = 0;
  int         errors = 0;
  logic       prev_exp = 1'b0;
  typedef struct packed {logic out; logic err;} exp_t;
  exp_t sb[$];

  multiplexer #(.WIDTH(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a),
    .B        (b),
    .ADDR     (addr),
    .OUTPUT   (out_w),
    .ADDR_ERR (err_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ia, input logic ib, input logic [2:0] iaddr, input string tag);
    exp_t e;
    exp_t g;
    a    = ia;
    b    = ib;
    addr = iaddr;
    if (iaddr === 3'b001)      e = '{out: ia, err: 1'b0};
    else if (iaddr === 3'b010) e = '{out: ib, err: 1'b0};
`ifdef MULTIPLEXER_HOLD_ON_INVALID_EN
    else                       e = '{out: prev_exp, err: 1'b1};
`else
    else                       e = '{out: 1'b0, err: 1'b1};
`endif
    prev_exp = e.out;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.sb: got empty scoreboard expected entry", tag);
    end else begin
      g = sb.pop_front();
      check({tag, ".out"}, out_w, g.out);
      check({tag, ".err"}, err_w, g.err);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 1'b1;
    b     = 1'b1;
    addr  = 3'b001;
    #3;
    check("rst_async.out", out_w, 1'b0);
    check("rst_async.err", err_w, 1'b0);
    #90;
    check("rst_hold.out", out_w, 1'b0);
    check("rst_hold.err", err_w, 1'b0);
    #7;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 3'b001, "selA_00");
    step(1'b1, 1'b0, 3'b001, "selA_10");
    step(1'b0, 1'b1, 3'b001, "selA_01");
    step(1'b1, 1'b1, 3'b001, "selA_11");
    step(1'b0, 1'b1, 3'b010, "selB_01");
    step(1'b0, 1'b0, 3'b010, "selB_00");
    step(1'b1, 1'b0, 3'b010, "selB_10");
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, (i % 2 == 0) ? 3'b001 : 3'b010, $sformatf("alt%0d", i));
    step(1'b1, 1'b0, 3'b001, "pre_ill");
    step(1'b1, 1'b1, 3'b000, "ill_000");
    step(1'b1, 1'b1, 3'b011, "ill_011");
    step(1'b1, 1'b1, 3'b111, "ill_111");
    step(1'b1, 1'b1, 3'b100, "ill_100");
    step(1'b1, 1'b1, 3'b101, "ill_101");
    step(1'b1, 1'b1, 3'b110, "ill_110");
    step(1'b1, 1'b1, 3'bx0x, "ill_x");
    step(1'b0, 1'b1, 3'b010, "recover");
    step(1'b1, 1'b0, 3'b001, "pre_mid");
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst.out", out_w, 1'b0);
    check("mid_rst.err", err_w, 1'b0);
    #2;
    rst_n = 1'b1;
    prev_exp = 1'b0;
    step(1'b1, 1'b0, 3'b001, "post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
